// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus: PC/instruction to memory, control inputs, IF/ID register outputs.
// The master modport is the fetch unit's view; slave is the surrounding pipeline/memory.
interface fetch_unit_if;
    logic [7:0] pc_out;
    logic [7:0] instr_in;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] if_instr;
    logic [7:0] if_pc;
    logic       if_valid;
    logic       halted;

    modport master (
        output pc_out, if_instr, if_pc, if_valid, halted,
        input  instr_in, stall, branch_taken, branch_target
    );

    modport slave (
        input  pc_out, if_instr, if_pc, if_valid, halted,
        output instr_in, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch with early jump resolution, stall, branch redirect
// and halt on out-of-range PC. Fills the IF/ID register one cycle after the PC read.
module fetch_unit #(
    parameter logic [7:0]  RESET_PC  = 8'd0,
    parameter int unsigned MEM_DEPTH = 32
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    typedef enum logic {S_RUN, S_HALT} state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] if_instr_q, if_instr_d;
    logic [7:0] if_pc_q, if_pc_d;
    logic       if_valid_q, if_valid_d;

    logic       is_jump;
    logic [7:0] jump_target;
    logic [7:0] seq_next;

    function automatic logic out_of_range(input logic [7:0] addr);
        return 32'(addr) >= MEM_DEPTH;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    always_comb begin
        is_jump     = (bus.instr_in[7:6] == 2'b11);
        jump_target = pc_q + 8'd1 + {{2{bus.instr_in[5]}}, bus.instr_in[5:0]};
        seq_next    = is_jump ? jump_target : pc_q + 8'd1;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        if (bus.branch_taken) begin
            pc_d       = bus.branch_target;
            if_valid_d = 1'b0;
            state_d    = out_of_range(bus.branch_target) ? S_HALT : S_RUN;
        end else begin
            case (state_q)
                S_HALT: if_valid_d = 1'b0;
                S_RUN: begin
                    // Only reachable with an out-of-range PC straight after reset.
                    if (out_of_range(pc_q)) begin
                        state_d    = S_HALT;
                        if_valid_d = 1'b0;
                    end else if (!bus.stall) begin
                        if_instr_d = bus.instr_in;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = seq_next;
                        if (out_of_range(seq_next)) state_d = S_HALT;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_comb begin
        bus.pc_out   = pc_q;
        bus.if_instr = if_instr_q;
        bus.if_pc    = if_pc_q;
        bus.if_valid = if_valid_q;
        bus.halted   = (state_q == S_HALT);
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, jumps, stall, branch, halt.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    logic rst2;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] mem [0:255];

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(.RESET_PC(8'd0), .MEM_DEPTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_unit #(.RESET_PC(8'd40), .MEM_DEPTH(32)) dut_oor (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    assign bus.instr_in  = mem[bus.pc_out];
    assign bus2.instr_in = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic [7:0] pc, input logic [7:0] instr,
                          input logic [7:0] ipc, input logic v, input logic h);
        check({tag, ".pc_out"},   32'(bus.pc_out),   32'(pc));
        check({tag, ".if_instr"}, 32'(bus.if_instr), 32'(instr));
        check({tag, ".if_pc"},    32'(bus.if_pc),    32'(ipc));
        check({tag, ".if_valid"}, 32'(bus.if_valid), 32'(v));
        check({tag, ".halted"},   32'(bus.halted),   32'(h));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h49;
        mem[1] = 8'h0C;
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h11;
        bus2.stall         = 1'b0;
        bus2.branch_taken  = 1'b0;
        bus2.branch_target = 8'h00;
        reset = 1'b1;
        rst2  = 1'b1;
        tick();
        tick();
        chk_if("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("oor_reset.pc", 32'(bus2.pc_out), 32'd40);
        check("oor_reset.halted", 32'(bus2.halted), 32'd0);
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        reset = 1'b0;
        rst2  = 1'b0;
        tick();
        chk_if("run", 8'h01, 8'h49, 8'h00, 1'b1, 1'b0);
        check("oor_first.pc", 32'(bus2.pc_out), 32'd40);
        check("oor_first.halted", 32'(bus2.halted), 32'd1);
        check("oor_first.valid", 32'(bus2.if_valid), 32'd0);

        // Forward jump, then stall at PC=4
        reset = 1'b1;
        mem[1] = 8'hC1;
        mem[3] = 8'h12;
        mem[4] = 8'h34;
        tick();
        reset = 1'b0;
        tick();
        chk_if("pre_jump", 8'h01, 8'h49, 8'h00, 1'b1, 1'b0);
        tick();
        chk_if("jump", 8'h03, 8'hC1, 8'h01, 1'b1, 1'b0);
        tick();
        chk_if("post_jump", 8'h04, 8'h12, 8'h03, 1'b1, 1'b0);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_if("stall", 8'h04, 8'h12, 8'h03, 1'b1, 1'b0);
        end
        bus.stall = 1'b0;
        tick();
        chk_if("stall_rel", 8'h05, 8'h34, 8'h04, 1'b1, 1'b0);

        // Branch overrides stall; then backward jump
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h08;
        mem[7] = 8'h55;
        mem[8] = 8'h77;
        mem[9] = 8'hFD;
        tick();
        chk_if("br_stall", 8'h08, 8'h34, 8'h04, 1'b0, 1'b0);
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        tick();
        chk_if("after_br", 8'h09, 8'h77, 8'h08, 1'b1, 1'b0);
        tick();
        chk_if("bjump", 8'h07, 8'hFD, 8'h09, 1'b1, 1'b0);
        tick();
        chk_if("post_bjump", 8'h08, 8'h55, 8'h07, 1'b1, 1'b0);

        // Run off the end of memory, then recover with a branch
        mem[30] = 8'h01;
        mem[31] = 8'h02;
        mem[2]  = 8'h21;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'd30;
        tick();
        chk_if("br30", 8'd30, 8'h55, 8'h07, 1'b0, 1'b0);
        bus.branch_taken = 1'b0;
        tick();
        chk_if("pc31", 8'd31, 8'h01, 8'd30, 1'b1, 1'b0);
        tick();
        chk_if("halt_edge", 8'd32, 8'h02, 8'd31, 1'b1, 1'b1);
        tick();
        chk_if("halted1", 8'd32, 8'h02, 8'd31, 1'b0, 1'b1);
        bus.stall = 1'b1;
        tick();
        chk_if("halted2", 8'd32, 8'h02, 8'd31, 1'b0, 1'b1);
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h02;
        tick();
        chk_if("unhalt", 8'h02, 8'h02, 8'd31, 1'b0, 1'b0);
        bus.branch_taken = 1'b0;
        tick();
        chk_if("resume", 8'h03, 8'h21, 8'h02, 1'b1, 1'b0);

        // Reset while a jump byte is on instr_in
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("mid_jump.instr_in", 32'(bus.instr_in), 32'h000000C1);
        reset     = 1'b1;
        bus.stall = 1'b1;
        tick();
        chk_if("rst_jump", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        reset     = 1'b0;
        bus.stall = 1'b0;
        tick();
        chk_if("rst_resume", 8'h01, 8'h49, 8'h00, 1'b1, 1'b0);

        // Jump that wraps below zero lands out of range
        mem[0] = 8'hFE;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk_if("wrap", 8'hFF, 8'hFE, 8'h00, 1'b1, 1'b1);
        tick();
        chk_if("wrap_hold", 8'hFF, 8'hFE, 8'h00, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
